// File: rtl/pattern_serializer.sv
// pattern_serializer
//   Sends a latched 4-bit pattern MSB first, one bit per clock. The pattern is
//   repeated reps+1 times, with gap idle bit-times between repetitions, and a
//   one-cycle done pulse follows the last bit.
//
//   state | meaning
//   IDLE  | waiting for start, line at IDLE_LEVEL
//   SHIFT | a pattern bit is on ser_out
//   GAP   | idle bit-times between repetitions
//   DONE  | one-cycle completion pulse, then back to IDLE
//
// Ports
//   clock     in   single clock, rising edge
//   rst_n     in   synchronous active-low reset
//   start     in   begin a transmission (sampled in IDLE only)
//   pattern   in   [3:0] pattern, latched on accepted start
//   reps      in   [2:0] repetition count minus one, latched on accepted start
//   gap       in   [1:0] idle bit-times between repetitions, latched on start
//   ser_out   out  serial data, IDLE_LEVEL when no pattern bit is sent
//   ser_valid out  ser_out carries a pattern bit
//   busy      out  transmission in SHIFT or GAP
//   done      out  one-cycle completion pulse
module pattern_serializer #(
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] pattern,
  input  logic [2:0] reps,
  input  logic [1:0] gap,
  output logic       ser_out,
  output logic       ser_valid,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t     state;
  logic [3:0] pat_q;
  logic [2:0] rep_cnt;
  logic [1:0] gap_q;
  logic [1:0] gap_cnt;
  // Index of the pattern bit currently presented on ser_out.
  logic [1:0] bit_idx;

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      pat_q     <= 4'd0;
      rep_cnt   <= 3'd0;
      gap_q     <= 2'd0;
      gap_cnt   <= 2'd0;
      bit_idx   <= 2'd0;
      ser_out   <= IDLE_LEVEL;
      ser_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done      <= 1'b0;
          ser_out   <= IDLE_LEVEL;
          ser_valid <= 1'b0;
          busy      <= 1'b0;
          if (start) begin
            pat_q     <= pattern;
            rep_cnt   <= reps;
            gap_q     <= gap;
            bit_idx   <= 2'd3;
            ser_out   <= pattern[3];
            ser_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          if (bit_idx != 2'd0) begin
            bit_idx <= bit_idx - 2'd1;
            ser_out <= pat_q[bit_idx - 2'd1];
          end else if (rep_cnt == 3'd0) begin
            // Last bit of the final repetition: no trailing gap.
            ser_out   <= IDLE_LEVEL;
            ser_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= ST_DONE;
          end else begin
            rep_cnt <= rep_cnt - 3'd1;
            if (gap_q == 2'd0) begin
              bit_idx <= 2'd3;
              ser_out <= pat_q[3];
            end else begin
              // gap_cnt holds the gap cycles remaining after the first one.
              gap_cnt   <= gap_q - 2'd1;
              ser_out   <= IDLE_LEVEL;
              ser_valid <= 1'b0;
              state     <= ST_GAP;
            end
          end
        end

        ST_GAP: begin
          if (gap_cnt == 2'd0) begin
            bit_idx   <= 2'd3;
            ser_out   <= pat_q[3];
            ser_valid <= 1'b1;
            state     <= ST_SHIFT;
          end else begin
            gap_cnt <= gap_cnt - 2'd1;
          end
        end

        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          ser_out   <= IDLE_LEVEL;
          ser_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_serializer.sv
module tb_pattern_serializer;

  logic       clock = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] pattern;
  logic [2:0] reps;
  logic [1:0] gap;
  logic       ser_out0, ser_valid0, busy0, done0;
  logic       ser_out1, ser_valid1, busy1, done1;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  pattern_serializer #(.IDLE_LEVEL(1'b0)) dut0 (
    .clock(clock), .rst_n(rst_n), .start(start), .pattern(pattern),
    .reps(reps), .gap(gap), .ser_out(ser_out0), .ser_valid(ser_valid0),
    .busy(busy0), .done(done0)
  );

  pattern_serializer #(.IDLE_LEVEL(1'b1)) dut1 (
    .clock(clock), .rst_n(rst_n), .start(start), .pattern(pattern),
    .reps(reps), .gap(gap), .ser_out(ser_out1), .ser_valid(ser_valid1),
    .busy(busy1), .done(done1)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; pattern = 4'hF; reps = 3'd7; gap = 2'd3;
    tick();
    tick();
    checks++;
    if ({ser_out0, ser_valid0, busy0, done0} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_dut0: got out/valid/busy/done=%b required 0000",
               {ser_out0, ser_valid0, busy0, done0});
    end
    checks++;
    if ({ser_out1, ser_valid1, busy1, done1} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_dut1: got out/valid/busy/done=%b required 1000",
               {ser_out1, ser_valid1, busy1, done1});
    end
    // start was high throughout reset; it must not have been taken.
    rst_n = 1'b1; start = 1'b0;
    tick();
    checks++;
    if ({ser_valid0, busy0, ser_valid1, busy1} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_start_ignored: got valid/busy=%b required 0000",
               {ser_valid0, busy0, ser_valid1, busy1});
    end
  endtask

  // Reference: the transmission as a per-cycle list built directly from the
  // rule "reps+1 copies of the pattern MSB first, gap idle slots between
  // copies, then one done cycle". Optionally scrambles inputs mid-flight.
  task automatic test_stream(input string name, input logic [3:0] pat,
                             input logic [2:0] r, input logic [1:0] g,
                             input bit disturb);
    bit eb[$], ev[$], ebz[$], ed[$];
    bit bits[$];
    int n, busy_seen, exp_busy_cnt, exp_det, det, nvalid;
    logic [3:0] sh;
    logic       eo0, eo1;
    for (int rep = 0; rep <= int'(r); rep++) begin
      for (int b = 3; b >= 0; b--) begin
        eb.push_back(pat[b]); ev.push_back(1'b1); ebz.push_back(1'b1); ed.push_back(1'b0);
        bits.push_back(pat[b]);
      end
      if (rep < int'(r))
        for (int k = 0; k < int'(g); k++) begin
          eb.push_back(1'b0); ev.push_back(1'b0); ebz.push_back(1'b1); ed.push_back(1'b0);
        end
    end
    eb.push_back(1'b0); ev.push_back(1'b0); ebz.push_back(1'b0); ed.push_back(1'b1);
    n = eb.size();
    exp_busy_cnt = (int'(r) + 1) * 4 + int'(r) * int'(g);
    exp_det = 0;
    for (int j = 0; j + 3 < bits.size(); j++)
      if ({bits[j], bits[j+1], bits[j+2], bits[j+3]} == pat) exp_det++;

    pattern = pat; reps = r; gap = g; start = 1'b1;
    tick();
    busy_seen = 0; det = 0; nvalid = 0; sh = 4'd0;
    for (int i = 0; i < n + 2; i++) begin
      bit xb, xv, xbz, xd;
      xb = (i < n) ? eb[i] : 1'b0;
      xv = (i < n) ? ev[i] : 1'b0;
      xbz = (i < n) ? ebz[i] : 1'b0;
      xd = (i < n) ? ed[i] : 1'b0;
      eo0 = xv ? xb : 1'b0;
      eo1 = xv ? xb : 1'b1;
      checks++;
      if ({ser_out0, ser_valid0, busy0, done0} !== {eo0, xv, xbz, xd}) begin
        errors++;
        $display("FAIL %s dut0 cycle %0d: got out/valid/busy/done=%b required %b",
                 name, i, {ser_out0, ser_valid0, busy0, done0}, {eo0, xv, xbz, xd});
      end
      checks++;
      if ({ser_out1, ser_valid1, busy1, done1} !== {eo1, xv, xbz, xd}) begin
        errors++;
        $display("FAIL %s dut1 cycle %0d: got out/valid/busy/done=%b required %b",
                 name, i, {ser_out1, ser_valid1, busy1, done1}, {eo1, xv, xbz, xd});
      end
      if (busy0 === 1'b1) busy_seen++;
      if (ser_valid0 === 1'b1) begin
        sh = {sh[2:0], ser_out0};
        nvalid++;
        if (nvalid >= 4 && sh == pat) det++;
      end
      if (disturb && i < n - 1) begin
        start = 1'($urandom); pattern = 4'($urandom);
        reps = 3'($urandom); gap = 2'($urandom);
      end else begin
        start = 1'b0;
      end
      tick();
    end
    checks++;
    if (busy_seen != exp_busy_cnt) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d required %0d", name, busy_seen, exp_busy_cnt);
    end
    if (g == 2'd0) begin
      checks++;
      if (det != exp_det) begin
        errors++;
        $display("FAIL %s detections: got %0d required %0d", name, det, exp_det);
      end
    end
  endtask

  task automatic test_mid_reset();
    pattern = 4'($urandom); reps = 3'd3; gap = 2'($urandom); start = 1'b1;
    tick();           // bit 3 on the line
    start = 1'b0;
    tick();           // bit 2
    tick();           // bit 1: third bit
    checks++;
    if (busy0 !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_precondition: got busy=%b required 1", busy0);
    end
    rst_n = 1'b0; start = 1'b1;
    tick();
    checks++;
    if ({ser_out0, ser_valid0, busy0, done0, ser_out1, ser_valid1, busy1, done1} !== 8'b0000_1000) begin
      errors++;
      $display("FAIL mid_reset_abort: got %b required 00001000",
               {ser_out0, ser_valid0, busy0, done0, ser_out1, ser_valid1, busy1, done1});
    end
    rst_n = 1'b1; start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({ser_valid0, busy0, done0, ser_out1} !== 4'b0001) begin
        errors++;
        $display("FAIL mid_reset_quiet cycle %0d: got valid/busy/done/out1=%b required 0001",
                 i, {ser_valid0, busy0, done0, ser_out1});
      end
    end
    test_stream("after_reset", 4'($urandom), 3'd3, 2'($urandom), 1'b0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 25; t++)
      test_stream("random", 4'($urandom), 3'($urandom), 2'($urandom), 1'($urandom));
  endtask

  initial begin
    test_reset();
    test_stream("single_1011", 4'b1011, 3'd0, 2'd0, 1'b0);
    test_stream("gap_1100", 4'b1100, 3'd2, 2'd2, 1'b0);
    test_stream("back_to_back_1010", 4'b1010, 3'd1, 2'd0, 1'b0);
    test_stream("ignore_start", 4'b0110, 3'd2, 2'd1, 1'b1);
    test_mid_reset();
    test_stream("idle_level_0000", 4'b0000, 3'd1, 2'd3, 1'b0);
    test_stream("max_reps", 4'b1001, 3'd7, 2'd3, 1'b0);
    test_stream("max_reps_b2b", 4'b1111, 3'd7, 2'd0, 1'b0);
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pattern_serializer.md
PATTERN_SERIALIZER -- requirements
Module: pattern_serializer

Interface
REQ-001 The block SHALL have parameter IDLE_LEVEL, default 1'b0, giving the level driven on ser_out whenever no pattern bit is being sent.
REQ-002 The block SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-004 The block SHALL have port start, input, 1, a request to begin a transmission, sampled only in IDLE.
REQ-005 The block SHALL have port pattern, input, 4, the pattern to serialize, latched on an accepted start.
REQ-006 The block SHALL have port reps, input, 3, the repetition count minus one, latched on an accepted start (0 = 1 transmission, 7 = 8 transmissions).
REQ-007 The block SHALL have port gap, input, 2, the number of idle bit-times (0-3) between repetitions, latched on an accepted start.
REQ-008 The block SHALL have port ser_out, output, 1, the serial data.
REQ-009 The block SHALL have port ser_valid, output, 1, high when ser_out carries a pattern bit.
REQ-010 The block SHALL have port busy, output, 1, high while a transmission is in SHIFT or GAP.
REQ-011 The block SHALL have port done, output, 1, a one-cycle pulse on completion.

Function
REQ-012 The FSM SHALL have the states IDLE, SHIFT, GAP and DONE, with all outputs registered.
REQ-013 In IDLE with start=1 at edge k, the block SHALL latch pattern, reps and gap, enter SHIFT, and drive ser_out=pattern[3] with ser_valid=1 in cycle k+1.
REQ-014 The pattern SHALL be sent MSB first (pattern[3], [2], [1], [0]), one bit per clock, 4 cycles per repetition.
REQ-015 After bit [0], if repetitions remain and the latched gap>0, the block SHALL enter GAP for exactly gap cycles, with ser_valid=0 and ser_out=IDLE_LEVEL.
REQ-016 After bit [0], if repetitions remain and the latched gap=0, the next pattern[3] SHALL follow in the very next cycle, giving back-to-back bits.
REQ-017 After bit [0] of the final repetition, the block SHALL enter DONE with no trailing gap; DONE asserts done=1, busy=0, ser_valid=0 for exactly one cycle, then returns unconditionally to IDLE.
REQ-018 A transmission SHALL total (reps+1)*4 + reps*gap cycles of busy=1.
REQ-019 start SHALL be ignored in SHIFT, GAP and DONE, and input changes there SHALL have no effect on the transmission in progress.
REQ-020 The repetition counter SHALL be 3 bits, decrement after each completed repetition, and signal completion at zero without wrap-around.
REQ-021 Outside SHIFT, ser_out SHALL equal IDLE_LEVEL.
REQ-022 The bitstream SHALL, on a matching 4-bit overlapping detector fed from ser_out, produce one detection per repetition when gap=0, plus any overlaps the pattern itself creates.

Reset
REQ-023 With rst_n=0 at a rising edge, the block SHALL enter IDLE with ser_out=IDLE_LEVEL, ser_valid=0, busy=0, done=0, all counters and latched registers 0.
REQ-024 Reset asserted mid-transmission SHALL abort it at that edge, with no done pulse.
REQ-025 A start high during the reset cycle SHALL be ignored.

Verification
REQ-026 Scenario: pattern=4'b1011, reps=0, gap=0, start pulse -> ser_out 1,0,1,1 with ser_valid=1 for 4 cycles, done=1 in cycle 5, busy high cycles 1-4.
REQ-027 Scenario: pattern=4'b1100, reps=2, gap=2 -> 1100,00,1100,00,1100, ser_valid low only in the gap cycles, 16 busy cycles, then one done pulse.
REQ-028 Scenario: pattern=4'b1010, reps=1, gap=0 -> 8 contiguous valid bits 10101010, followed by the done pulse.
REQ-029 Scenario: start re-pulsed and pattern changed mid-SHIFT -> output stream unchanged, no restart.
REQ-030 Scenario: rst_n=0 during the third bit of a reps=3 transmission -> next cycle ser_valid=0, busy=0, done=0, ser_out=IDLE_LEVEL; a fresh start then runs normally.
REQ-031 Scenario: IDLE_LEVEL=1, pattern=4'b0000, reps=1, gap=3 -> ser_out reads 0000,111,0000, then idles at 1.
